fft_sdf_stage_cu: RTL and testbench
===================================

// Module: fft_sdf_stage_cu
// PURPOSE
//  Parametrised control unit for one radix-2 SDF FFT stage: butterfly enable/select, output valid, twiddle address.
//  Generalises the fixed 16-point stage controller to any power-of-2 DELAY and FRAME_LEN.
//  Adds input-valid stalls, frame-last marking and a flush/drain mode.
//  Sits between the previous stage's valid/alert outputs and this stage's butterfly + delay-line datapath.
// PARAMETERS
//  DELAY      16   butterfly delay-line depth in samples; power of 2, >=2
//  FRAME_LEN  64   FFT frame length in samples; power of 2, multiple of 2*DELAY
//  CW         $clog2(FRAME_LEN)  sample/twiddle counter width (derived, do not override)
// PORTS
//  clk        in   1    clock, all logic on rising edge
//  rst        in   1    reset
//  in_valid   in   1    input sample present this cycle
//  in_ready   out  1    stage accepts sample (accept = in_valid & in_ready)
//  flush      in   1    request drain of the delay line after the last input
//  bf_sel     out  1    butterfly mux select: 0 = load delay line, 1 = compute butterfly
//  bf_en      out  1    datapath advance (delay-line shift / butterfly register enable)
//  out_valid  out  1    stage output sample valid this cycle
//  out_last   out  1    out_valid sample is the last of its frame
//  tw_addr    out  CW   twiddle ROM address = output sample index within frame
//  alert_next out  1    1-cycle pulse on the first out_valid after a fill (wakes next stage)
//  done       out  1    1-cycle pulse when a drain completes
// BEHAVIOUR
//  Reset: one clock; reset is synchronous and active-high.
//   rst=1 at an edge -> state=IDLE, all counters 0, every output 0 except in_ready=1. Mid-operation reset aborts at once.
//  Internal regs: in_cnt (CW bits, accepted-sample index), out_cnt (CW bits), drain_cnt ($clog2(DELAY)+1 bits).
//  adv = accept (IDLE/FILL/RUN) or 1 (DRAIN); bf_en = adv (combinational).
//  bf_sel = in_cnt[$clog2(DELAY)] (registered-state-derived); low for the first DELAY samples of each 2*DELAY group.
//  in_cnt increments on adv and wraps FRAME_LEN-1 -> 0.
//  If in_valid=0 in FILL/RUN, nothing advances: counters hold, bf_en=0, out_valid=0.
//  FSM:
//   IDLE : in_ready=1. accept -> FILL (that sample counts as in_cnt 0). flush ignored.
//   FILL : out_valid=0. Accept with in_cnt==DELAY-1 -> RUN. flush -> IDLE, counters cleared, no outputs.
//   RUN  : out_valid = adv.
//     - First out_valid after FILL coincides with accept of in_cnt==DELAY; alert_next pulses in that cycle.
//     - flush=1 -> DRAIN next cycle. A sample accepted in the flush cycle is kept.
//   DRAIN: in_ready=0, in_valid ignored. adv=1 every cycle for exactly DELAY cycles.
//     - Drain samples are zeros injected by the datapath; out_valid=1 on each.
//     - Last drain cycle: done=1, then IDLE with in_cnt/out_cnt cleared.
//  out_cnt increments on each out_valid, wraps FRAME_LEN-1 -> 0. tw_addr = out_cnt.
//  out_last = out_valid & (out_cnt==FRAME_LEN-1).
//  Latency: stage output for input n appears on the advance that accepts input n+DELAY (or the DELAY-th drain cycle).
//  Simultaneous rst with any input: rst wins. flush with in_valid in FILL: flush wins, sample dropped.
// TESTING
//  1 DELAY=16,FRAME_LEN=64, rst then 64 back-to-back valids
//    -> bf_sel 0 for in 0-15, 1 for 16-31, 0 for 32-47, 1 for 48-63.
//    -> out_valid from in 16 on; alert_next one pulse at in 16; tw_addr 0..47.
//  2 Continuous 160 valids
//    -> out_last pulses exactly when tw_addr==63 (at in 79 and in 143).
//    -> in_cnt wraps; no alert_next after the first.
//  3 Random in_valid gaps (50% duty), 64 accepts
//    -> bf_en/out_valid only on accept cycles; tw_addr sequence identical to scenario 1, no skips or repeats.
//  4 64 accepts then flush=1 for one cycle
//    -> DRAIN: in_ready=0 for 16 cycles, out_valid=1 each, tw_addr 48..63, out_last on the 16th.
//    -> done pulse on the 16th cycle; IDLE next with in_ready=1.
//  5 Flush after 5 accepts (FILL)
//    -> back to IDLE next cycle; no out_valid, alert_next or done. Next accept restarts bf_sel at 0.
//  6 rst asserted in RUN at in 40
//    -> next cycle all outputs 0, in_ready=1. Restart reproduces scenario 1 exactly.

Source files
------------

// File: rtl/fft_sdf_stage_cu.sv
// Control unit for one radix-2 SDF FFT stage: sequences fill, run and drain of the
// delay line and produces butterfly select/enable, output valid/last and twiddle address.
module fft_sdf_stage_cu #(
  parameter int DELAY     = 16,
  parameter int FRAME_LEN = 64,
  parameter int CW        = $clog2(FRAME_LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          flush,
  output logic          bf_sel,
  output logic          bf_en,
  output logic          out_valid,
  output logic          out_last,
  output logic [CW-1:0] tw_addr,
  output logic          alert_next,
  output logic          done
);

  localparam int DW = $clog2(DELAY);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] in_cnt_reg;
  logic [CW-1:0] out_cnt_reg;
  logic [DW:0]   drain_cnt_reg;
  logic          first_reg;

  logic accept;
  logic adv;
  logic out_valid_c;
  logic drain_last;
  logic clear_cnt;

  always_comb begin
    in_ready    = (state_reg != S_DRAIN);
    accept      = in_valid & in_ready;
    adv         = 1'b0;
    out_valid_c = 1'b0;
    drain_last  = 1'b0;
    clear_cnt   = 1'b0;
    state_next  = state_reg;
    case (state_reg)
      S_IDLE: begin
        adv = accept;
        if (accept) state_next = S_FILL;
      end
      S_FILL: begin
        // flush takes priority: the sample offered in the same cycle is dropped
        if (flush) begin
          clear_cnt  = 1'b1;
          state_next = S_IDLE;
        end else begin
          adv = accept;
          if (accept && in_cnt_reg == CW'(DELAY - 1)) state_next = S_RUN;
        end
      end
      S_RUN: begin
        adv         = accept;
        out_valid_c = accept;
        if (flush) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        adv         = 1'b1;
        out_valid_c = 1'b1;
        drain_last  = (drain_cnt_reg == (DW + 1)'(DELAY - 1));
        if (drain_last) begin
          clear_cnt  = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign bf_en      = adv;
  assign bf_sel     = in_cnt_reg[DW];
  assign out_valid  = out_valid_c;
  assign out_last   = out_valid_c & (out_cnt_reg == CW'(FRAME_LEN - 1));
  assign tw_addr    = out_cnt_reg;
  assign alert_next = out_valid_c & first_reg;
  assign done       = drain_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      in_cnt_reg    <= '0;
      out_cnt_reg   <= '0;
      drain_cnt_reg <= '0;
      first_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (clear_cnt) begin
        in_cnt_reg    <= '0;
        out_cnt_reg   <= '0;
        drain_cnt_reg <= '0;
      end else begin
        // counters are exactly CW bits wide, so the FRAME_LEN-1 -> 0 wrap is natural
        if (adv)               in_cnt_reg    <= in_cnt_reg + CW'(1);
        if (out_valid_c)       out_cnt_reg   <= out_cnt_reg + CW'(1);
        if (state_reg == S_DRAIN) drain_cnt_reg <= drain_cnt_reg + (DW + 1)'(1);
      end
      if (state_reg == S_FILL && state_next == S_RUN)
        first_reg <= 1'b1;
      else if (out_valid_c || clear_cnt)
        first_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_sdf_stage_cu.sv
// Directed bench for fft_sdf_stage_cu (DELAY=16, FRAME_LEN=64): fill/run, frame wrap,
// stalls, flush/drain, flush in fill and mid-run reset.
module tb_fft_sdf_stage_cu;

  localparam int DELAY     = 16;
  localparam int FRAME_LEN = 64;
  localparam int CW        = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          flush = 1'b0;
  logic          bf_sel;
  logic          bf_en;
  logic          out_valid;
  logic          out_last;
  logic [CW-1:0] tw_addr;
  logic          alert_next;
  logic          done;

  int checks = 0;
  int errors = 0;

  fft_sdf_stage_cu #(.DELAY(DELAY), .FRAME_LEN(FRAME_LEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .flush      (flush),
    .bf_sel     (bf_sel),
    .bf_en      (bf_en),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .tw_addr    (tw_addr),
    .alert_next (alert_next),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply inputs after the falling edge; checks run 1ns later, before the next rising edge.
  task automatic cyc(input logic r, input logic v, input logic f);
    @(negedge clk);
    rst      = r;
    in_valid = v;
    flush    = f;
    #1;
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_bf_sel", 32'(bf_sel), 32'd0);
    chk("rst_bf_en", 32'(bf_en), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_tw_addr", 32'(tw_addr), 32'd0);
    chk("rst_alert", 32'(alert_next), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
  endtask

  // Back-to-back valids from a freshly idle stage; expectation by sample index i.
  task automatic run_fill(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'b1, 1'b0);
      chk($sformatf("s1_bf_en[%0d]", i), 32'(bf_en), 32'd1);
      chk($sformatf("s1_bf_sel[%0d]", i), 32'(bf_sel), 32'((i >> 4) & 1));
      chk($sformatf("s1_out_valid[%0d]", i), 32'(out_valid), 32'(i >= 16));
      chk($sformatf("s1_alert[%0d]", i), 32'(alert_next), 32'(i == 16));
      chk($sformatf("s1_tw[%0d]", i), 32'(tw_addr), (i >= 16) ? 32'(i - 16) : 32'd0);
      chk($sformatf("s1_last[%0d]", i), 32'(out_last), 32'd0);
      chk($sformatf("s1_done[%0d]", i), 32'(done), 32'd0);
    end
  endtask

  initial begin
    int acc;

    // 1: fill and run one frame, then 4: flush and drain
    do_reset();
    run_fill(64);
    cyc(1'b0, 1'b0, 1'b1);
    chk("s4_flush_out_valid", 32'(out_valid), 32'd0);
    chk("s4_flush_bf_en", 32'(bf_en), 32'd0);
    chk("s4_flush_in_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < DELAY; k++) begin
      cyc(1'b0, 1'b1, 1'b0);
      chk($sformatf("s4_in_ready[%0d]", k), 32'(in_ready), 32'd0);
      chk($sformatf("s4_out_valid[%0d]", k), 32'(out_valid), 32'd1);
      chk($sformatf("s4_bf_en[%0d]", k), 32'(bf_en), 32'd1);
      chk($sformatf("s4_tw[%0d]", k), 32'(tw_addr), 32'(48 + k));
      chk($sformatf("s4_last[%0d]", k), 32'(out_last), 32'(k == 15));
      chk($sformatf("s4_done[%0d]", k), 32'(done), 32'(k == 15));
      chk($sformatf("s4_alert[%0d]", k), 32'(alert_next), 32'd0);
    end
    cyc(1'b0, 1'b0, 1'b0);
    chk("s4_idle_in_ready", 32'(in_ready), 32'd1);
    chk("s4_idle_tw", 32'(tw_addr), 32'd0);
    chk("s4_idle_done", 32'(done), 32'd0);
    chk("s4_idle_out_valid", 32'(out_valid), 32'd0);

    // 2: continuous 160 valids across frame wraps
    do_reset();
    for (int i = 0; i < 160; i++) begin
      cyc(1'b0, 1'b1, 1'b0);
      chk($sformatf("s2_out_valid[%0d]", i), 32'(out_valid), 32'(i >= 16));
      chk($sformatf("s2_alert[%0d]", i), 32'(alert_next), 32'(i == 16));
      chk($sformatf("s2_tw[%0d]", i), 32'(tw_addr), (i >= 16) ? 32'((i - 16) % 64) : 32'd0);
      chk($sformatf("s2_last[%0d]", i), 32'(out_last), 32'(i == 79 || i == 143));
      chk($sformatf("s2_bf_sel[%0d]", i), 32'(bf_sel), 32'((i >> 4) & 1));
    end

    // 3: random stalls, 64 accepts
    do_reset();
    acc = 0;
    for (int c = 0; c < 1000 && acc < 64; c++) begin
      logic v;
      v = 1'($urandom_range(0, 1));
      cyc(1'b0, v, 1'b0);
      chk($sformatf("s3_bf_en[%0d]", c), 32'(bf_en), 32'(v));
      chk($sformatf("s3_out_valid[%0d]", c), 32'(out_valid), 32'(v && acc >= 16));
      chk($sformatf("s3_tw[%0d]", c), 32'(tw_addr), (acc >= 16) ? 32'(acc - 16) : 32'd0);
      chk($sformatf("s3_alert[%0d]", c), 32'(alert_next), 32'(v && acc == 16));
      if (v) acc++;
    end
    chk("s3_accept_count", 32'(acc), 32'd64);

    // 5: flush during fill drops the offered sample and returns to idle
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    chk("s5_flush_bf_en", 32'(bf_en), 32'd0);
    chk("s5_flush_out_valid", 32'(out_valid), 32'd0);
    chk("s5_flush_done", 32'(done), 32'd0);
    chk("s5_flush_alert", 32'(alert_next), 32'd0);
    run_fill(20);

    // 6: reset mid-run, then a clean restart
    do_reset();
    run_fill(40);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("s6_in_ready", 32'(in_ready), 32'd1);
    chk("s6_bf_sel", 32'(bf_sel), 32'd0);
    chk("s6_out_valid", 32'(out_valid), 32'd0);
    chk("s6_tw", 32'(tw_addr), 32'd0);
    chk("s6_alert", 32'(alert_next), 32'd0);
    chk("s6_done", 32'(done), 32'd0);
    run_fill(64);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
